axis_frame_length_adjust: RTL and testbench
===========================================

// Module: axis_frame_length_adjust
// PURPOSE
//  AXI-Stream frame length normaliser placed directly downstream of axis_fifo (consumes its m_axis).
//  Pads short frames with zero beats up to a minimum length.
//  Truncates long frames at a maximum length and discards the remainder.
//  Reports per-frame length status. One byte/beat; length counted in beats.
// PARAMETERS
//  DATA_WIDTH  8   tdata width (one beat = one length unit)
//  USER_WIDTH  1   tuser width
//  LEN_WIDTH   16  width of length config/status fields
// PORTS
//  clk                          in   1           clock, all logic rising-edge
//  rst_n                        in   1           async active-low reset
//  s_axis_tdata                 in   DATA_WIDTH  input data
//  s_axis_tvalid                in   1           input valid
//  s_axis_tready                out  1           input ready
//  s_axis_tlast                 in   1           input end of frame
//  s_axis_tuser                 in   USER_WIDTH  input user sideband
//  m_axis_tdata                 out  DATA_WIDTH  output data
//  m_axis_tvalid                out  1           output valid
//  m_axis_tready                in   1           output ready
//  m_axis_tlast                 out  1           output end of frame
//  m_axis_tuser                 out  USER_WIDTH  output user sideband
//  length_min                   in   LEN_WIDTH   pad target; 0/1 = no padding
//  length_max                   in   LEN_WIDTH   truncate limit; 0 = no truncation
//  status_valid                 out  1           1-cycle pulse per completed output frame
//  status_frame_pad             out  1           frame was padded
//  status_frame_truncate        out  1           frame was truncated
//  status_frame_length          out  LEN_WIDTH   beats emitted on m_axis
//  status_frame_original_length out  LEN_WIDTH   beats received on s_axis (saturating)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=TRANSFER, counters 0, m_axis_tvalid=0, status_valid=0.
//    All status fields are 0. The partial frame in progress is lost.
//    The first beat after reset release is the start of a new frame.
//  - Output stage: single register, 1-cycle latency s->m.
//    Output register loads when m_axis_tready || !m_axis_tvalid.
//    s_axis_tready is asserted only in TRANSFER with the output register able to load, or in TRUNCATE (always 1).
//    Data/last/user stay stable while m_axis_tvalid && !m_axis_tready.
//  - length_min/length_max are sampled on the first accepted beat of each frame.
//    Changes mid-frame have no effect.
//    Pad target = min(length_min, length_max) when length_max != 0.
//  - Counters: out_cnt and in_cnt are LEN_WIDTH bits and saturate at all-ones.
//  - FSM TRANSFER: on accepted beat, forward it and increment both counters.
//    If the beat is the max-th beat and s_axis_tlast=0: output tlast=1, truncate=1, -> TRUNCATE.
//    If s_axis_tlast=1 and out_cnt+1 < pad target: output tlast=0, save tuser, pad=1, -> PAD.
//    If s_axis_tlast=1 otherwise: output as is, frame complete.
//    A beat that is simultaneously the max-th beat and last is forwarded as a normal last beat (not truncated).
//  - FSM PAD: s_axis_tready=0. Emit beats with tdata=0, tuser=0 whenever the output register can load.
//    The final pad beat (out_cnt reaches target) has tlast=1 and tuser = saved last tuser. -> TRANSFER.
//  - FSM TRUNCATE: s_axis_tready=1; accept and drop beats, incrementing in_cnt only.
//    On the dropped beat with tlast=1 -> TRANSFER.
//  - Status: status_valid pulses for 1 cycle, one cycle after frame completion.
//    Completion = last output beat loaded into the register, or, for truncated frames, the dropped tlast beat accepted.
//    Fields hold their value until the next pulse.
//    The next frame may start in the same cycle as the pulse.
// TESTING
//  1 min=8,max=0; 3-beat frame AA,BB,CC(last) -> out AA,BB,CC,00x5, tlast on 8th.
//    status len=8, orig=3, pad=1.
//  2 min=0,max=4; 10-beat frame 01..0A -> out 01..04, tlast on 04; 05..0A accepted and dropped.
//    status len=4, orig=10, truncate=1.
//  3 min=4,max=4; 4-beat frame, last on 4th -> passed unchanged, pad=0, truncate=0.
//  4 min=2; 1-beat frame tuser=1, m_axis_tready toggling 1010 -> 2 beats out, 2nd tuser=1, tlast=1.
//    No beat lost or duplicated.
//  5 rst_n low during PAD after 2 of 6 beats -> m_axis_tvalid=0 immediately.
//    Next input frame handled from count 0.
//  6 back-to-back 1-beat frames, min=0, max=0, m_axis_tready=1 -> 1 beat/cycle throughput, one status pulse per frame.

Source files
------------

// File: rtl/axis_frame_length_adjust.sv
// AXI-Stream frame length normaliser: pads short frames with zero beats up to a
// minimum length, truncates long frames at a maximum length, reports per-frame status.
module axis_frame_length_adjust #(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic [LEN_WIDTH-1:0]  length_min,
  input  logic [LEN_WIDTH-1:0]  length_max,
  output logic                  status_valid,
  output logic                  status_frame_pad,
  output logic                  status_frame_truncate,
  output logic [LEN_WIDTH-1:0]  status_frame_length,
  output logic [LEN_WIDTH-1:0]  status_frame_original_length
);

  typedef enum logic [1:0] {TRANSFER, PAD, TRUNCATE} state_t;

  state_t                state;
  logic [LEN_WIDTH-1:0]  out_cnt;
  logic [LEN_WIDTH-1:0]  in_cnt;
  logic [LEN_WIDTH-1:0]  target_reg;
  logic [LEN_WIDTH-1:0]  max_reg;
  logic [USER_WIDTH-1:0] saved_user;

  logic                  load;
  logic                  accept;
  logic                  frame_start;
  logic [LEN_WIDTH-1:0]  cur_max;
  logic [LEN_WIDTH-1:0]  cur_target;
  logic [LEN_WIDTH-1:0]  out_next;
  logic [LEN_WIDTH-1:0]  in_next;
  logic                  at_max;
  logic                  below_target;

  assign load          = m_axis_tready || !m_axis_tvalid;
  assign s_axis_tready = ((state == TRANSFER) && load) || (state == TRUNCATE);
  assign accept        = s_axis_tvalid && s_axis_tready;

  // A zero out_cnt in TRANSFER means no beat of the current frame has been taken
  // yet, so the live config inputs are used; afterwards the captured copies apply.
  assign frame_start = (state == TRANSFER) && (out_cnt == '0);
  assign cur_max     = frame_start ? length_max : max_reg;
  assign cur_target  = frame_start ?
                       (((length_max != '0) && (length_max < length_min)) ? length_max : length_min) :
                       target_reg;

  assign out_next     = (&out_cnt) ? out_cnt : out_cnt + LEN_WIDTH'(1);
  assign in_next      = (&in_cnt) ? in_cnt : in_cnt + LEN_WIDTH'(1);
  assign at_max       = (cur_max != '0) && (out_next == cur_max);
  assign below_target = out_next < cur_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                        <= TRANSFER;
      out_cnt                      <= '0;
      in_cnt                       <= '0;
      target_reg                   <= '0;
      max_reg                      <= '0;
      saved_user                   <= '0;
      m_axis_tdata                 <= '0;
      m_axis_tvalid                <= 1'b0;
      m_axis_tlast                 <= 1'b0;
      m_axis_tuser                 <= '0;
      status_valid                 <= 1'b0;
      status_frame_pad             <= 1'b0;
      status_frame_truncate        <= 1'b0;
      status_frame_length          <= '0;
      status_frame_original_length <= '0;
    end else begin
      status_valid <= 1'b0;
      case (state)
        TRANSFER: begin
          if (load) m_axis_tvalid <= s_axis_tvalid;
          if (accept) begin
            m_axis_tdata <= s_axis_tdata;
            m_axis_tuser <= s_axis_tuser;
            out_cnt      <= out_next;
            in_cnt       <= in_next;
            target_reg   <= cur_target;
            max_reg      <= cur_max;
            // A last beat that lands exactly on the max is a normal end, not a truncation.
            if (s_axis_tlast) begin
              if (below_target) begin
                m_axis_tlast <= 1'b0;
                saved_user   <= s_axis_tuser;
                state        <= PAD;
              end else begin
                m_axis_tlast                 <= 1'b1;
                status_valid                 <= 1'b1;
                status_frame_pad             <= 1'b0;
                status_frame_truncate        <= 1'b0;
                status_frame_length          <= out_next;
                status_frame_original_length <= in_next;
                out_cnt                      <= '0;
                in_cnt                       <= '0;
              end
            end else if (at_max) begin
              m_axis_tlast <= 1'b1;
              state        <= TRUNCATE;
            end else begin
              m_axis_tlast <= 1'b0;
            end
          end
        end
        PAD: begin
          if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= '0;
            out_cnt       <= out_next;
            if (!below_target) begin
              m_axis_tlast                 <= 1'b1;
              m_axis_tuser                 <= saved_user;
              status_valid                 <= 1'b1;
              status_frame_pad             <= 1'b1;
              status_frame_truncate        <= 1'b0;
              status_frame_length          <= out_next;
              status_frame_original_length <= in_cnt;
              out_cnt                      <= '0;
              in_cnt                       <= '0;
              state                        <= TRANSFER;
            end else begin
              m_axis_tlast <= 1'b0;
              m_axis_tuser <= '0;
            end
          end
        end
        TRUNCATE: begin
          if (load) m_axis_tvalid <= 1'b0;
          if (accept) begin
            in_cnt <= in_next;
            if (s_axis_tlast) begin
              status_valid                 <= 1'b1;
              status_frame_pad             <= 1'b0;
              status_frame_truncate        <= 1'b1;
              status_frame_length          <= out_cnt;
              status_frame_original_length <= in_next;
              out_cnt                      <= '0;
              in_cnt                       <= '0;
              state                        <= TRANSFER;
            end
          end
        end
        default: state <= TRANSFER;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_length_adjust.sv
// Directed bench for axis_frame_length_adjust: a frame model fills beat and status
// scoreboards as stimulus is driven; negedge monitors pop and compare DUT output.
module tb_axis_frame_length_adjust;

  logic        clk;
  logic        rst_n;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [0:0]  s_axis_tuser;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [0:0]  m_axis_tuser;
  logic [15:0] length_min;
  logic [15:0] length_max;
  logic        status_valid;
  logic        status_frame_pad;
  logic        status_frame_truncate;
  logic [15:0] status_frame_length;
  logic [15:0] status_frame_original_length;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
    logic       chk;
  } beat_t;

  typedef struct packed {
    logic [15:0] len;
    logic [15:0] orig;
    logic        pad;
    logic        trunc;
  } status_t;

  beat_t   exp_q[$];
  status_t stat_q[$];
  beat_t   mon_b;
  status_t mon_s;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int beats_seen = 0;
  int pulses_seen = 0;
  bit toggle_mode = 0;

  axis_frame_length_adjust dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .s_axis_tdata                 (s_axis_tdata),
    .s_axis_tvalid                (s_axis_tvalid),
    .s_axis_tready                (s_axis_tready),
    .s_axis_tlast                 (s_axis_tlast),
    .s_axis_tuser                 (s_axis_tuser),
    .m_axis_tdata                 (m_axis_tdata),
    .m_axis_tvalid                (m_axis_tvalid),
    .m_axis_tready                (m_axis_tready),
    .m_axis_tlast                 (m_axis_tlast),
    .m_axis_tuser                 (m_axis_tuser),
    .length_min                   (length_min),
    .length_max                   (length_max),
    .status_valid                 (status_valid),
    .status_frame_pad             (status_frame_pad),
    .status_frame_truncate        (status_frame_truncate),
    .status_frame_length          (status_frame_length),
    .status_frame_original_length (status_frame_original_length)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output side is sampled mid-cycle, where every handshake signal is settled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checkOutput("beat_unexpected", 64'd1, 64'd0);
        end else begin
          mon_b = exp_q.pop_front();
          checkOutput("beat", {m_axis_tdata, m_axis_tlast, m_axis_tuser[0] & mon_b.chk},
                      {mon_b.data, mon_b.last, mon_b.user & mon_b.chk});
          beats_seen++;
        end
      end
      if (status_valid) begin
        pulses_seen++;
        if (stat_q.size() == 0) begin
          checkOutput("status_unexpected", 64'd1, 64'd0);
        end else begin
          mon_s = stat_q.pop_front();
          checkOutput("status", {status_frame_length, status_frame_original_length,
                                 status_frame_pad, status_frame_truncate}, mon_s);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    m_axis_tready = toggle_mode ? ~m_axis_tready : 1'b1;
  endtask

  task automatic sendBeat(input logic [7:0] d, input logic l, input logic u);
    bit acc;
    int guard;
    guard = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    do begin
      @(negedge clk);
      acc = s_axis_tready;
      tick();
      guard++;
    end while (!acc && guard < 100);
    if (!acc) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  // Models the expected output of one frame, queues it, then drives the frame.
  task automatic applyStimulus(input int n, input logic [15:0] mn, input logic [15:0] mx,
                               input logic [7:0] base, input logic [7:0] step,
                               input logic last_user, input bit scramble);
    logic [15:0] tgt;
    beat_t   b;
    status_t st;
    tgt = ((mx != 16'd0) && (mx < mn)) ? mx : mn;
    length_min = mn;
    length_max = mx;
    if ((mx != 16'd0) && (n > int'(mx))) begin
      for (int i = 0; i < int'(mx); i++) begin
        b.data = 8'(int'(base) + i * int'(step));
        b.last = (i == int'(mx) - 1);
        b.user = 1'b0;
        b.chk  = 1'b1;
        exp_q.push_back(b);
      end
      st.len = mx; st.orig = 16'(n); st.pad = 1'b0; st.trunc = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) begin
        b.data = 8'(int'(base) + i * int'(step));
        b.last = (i == n - 1) && !(n < int'(tgt));
        b.user = (i == n - 1) ? last_user : 1'b0;
        b.chk  = !((i == n - 1) && (n < int'(tgt)));
        exp_q.push_back(b);
      end
      for (int i = n; i < int'(tgt); i++) begin
        b.data = 8'h00;
        b.last = (i == int'(tgt) - 1);
        b.user = (i == int'(tgt) - 1) ? last_user : 1'b0;
        b.chk  = 1'b1;
        exp_q.push_back(b);
      end
      st.len   = (n < int'(tgt)) ? tgt : 16'(n);
      st.orig  = 16'(n);
      st.pad   = (n < int'(tgt));
      st.trunc = 1'b0;
    end
    stat_q.push_back(st);
    for (int i = 0; i < n; i++) begin
      sendBeat(8'(int'(base) + i * int'(step)), (i == n - 1), (i == n - 1) ? last_user : 1'b0);
      if (scramble && i == 0) begin
        length_min = 16'd1;
        length_max = 16'd1;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || stat_q.size() != 0) && g < 300) begin
      tick();
      g++;
    end
    checkOutput("drain", 64'(exp_q.size() + stat_q.size()), 64'd0);
  endtask

  initial begin
    int start;
    int c0;
    int p0;
    rst_n         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = '0;
    m_axis_tready = 1'b1;
    length_min    = '0;
    length_max    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("[TB] reset released");
    checkOutput("reset_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("reset_s_tready", 64'(s_axis_tready), 64'd1);
    checkOutput("reset_status_valid", 64'(status_valid), 64'd0);
    checkOutput("reset_status_fields", {status_frame_length, status_frame_original_length,
                status_frame_pad, status_frame_truncate}, 64'd0);

    $display("[TB] pad 3 beats to 8, config changed mid-frame");
    applyStimulus(3, 16'd8, 16'd0, 8'hAA, 8'h11, 1'b0, 1'b1);
    drain();

    $display("[TB] truncate 10 beats at 4");
    applyStimulus(10, 16'd0, 16'd4, 8'h01, 8'h01, 1'b0, 1'b0);
    drain();

    $display("[TB] exact length 4 with min=max=4");
    applyStimulus(4, 16'd4, 16'd4, 8'h10, 8'h01, 1'b1, 1'b0);
    drain();
    repeat (3) tick();
    checkOutput("status_hold_len", 64'(status_frame_length), 64'd4);
    checkOutput("status_hold_flags", {status_frame_pad, status_frame_truncate}, 64'd0);

    $display("[TB] pad 1 beat to 2 with toggling ready");
    toggle_mode = 1;
    start = beats_seen;
    applyStimulus(1, 16'd2, 16'd0, 8'h5A, 8'h00, 1'b1, 1'b0);
    drain();
    checkOutput("toggle_beat_count", 64'(beats_seen - start), 64'd2);
    toggle_mode = 0;
    tick();

    $display("[TB] reset during padding");
    start = beats_seen;
    applyStimulus(2, 16'd8, 16'd0, 8'h70, 8'h01, 1'b0, 1'b0);
    c0 = 0;
    while (beats_seen < start + 4 && c0 < 100) begin
      tick();
      c0++;
    end
    checkOutput("pad_progress", 64'(beats_seen - start), 64'd4);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("midreset_status", {status_valid, status_frame_length}, 64'd0);
    exp_q.delete();
    stat_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(3, 16'd0, 16'd0, 8'h30, 8'h01, 1'b1, 1'b0);
    drain();

    $display("[TB] back-to-back single-beat frames");
    p0 = pulses_seen;
    c0 = cyc;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 16'd0, 16'd0, 8'(8'hC0 + k), 8'h00, k[0], 1'b0);
    end
    checkOutput("throughput_cycles", 64'(cyc - c0), 64'd5);
    drain();
    checkOutput("status_pulse_count", 64'(pulses_seen - p0), 64'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
